path_stack_queue: RTL

- Parametrised location store for the maze/path-search datapath.
- During search it is a LIFO: the solver pushes each visited cell and pops on backtrack.
- After the solver finishes, it replays the surviving path bottom-to-top as a FIFO stream over a valid/ready handshake to the move/output stage.
- Adds width/depth generics, full/empty/count status, sticky error flags, push+pop replace, and a stall-safe replay interface.

---
 rtl/path_pkg.sv | 30 +++
 rtl/path_mem.sv | 32 +++
 rtl/path_stack_queue.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/path_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | path_pkg: shared types and helpers for the path stack/queue store   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package path_pkg;

   typedef enum logic [1:0] {
      SEARCH   = 2'd0,
      REPLAY   = 2'd1,
      FINISHED = 2'd2
   } path_state_e;

   // Location word layout for the default 8-bit {x,y} packing
   localparam int X_HI = 7;
   localparam int X_LO = 4;
   localparam int Y_HI = 3;
   localparam int Y_LO = 0;

   // Count must be able to represent DEPTH itself, hence DEPTH+1
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/path_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | path_mem: DEPTH x DATA_W storage, synchronous write, read data      |
// | sampled by the caller's output registers. Revision: 1.0             |
// +--------------------------------------------------------------------+
module path_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Contents are intentionally not reset; a read in the same cycle as a
   // write to the same address returns the old word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/path_stack_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | path_stack_queue: LIFO during search, in-order FIFO replay after    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module path_stack_queue
   import path_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 256,
   localparam int CNT_W  = cnt_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   input  logic              replay_start,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              replay_done,
   output logic [1:0]        mode,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int AW = addr_width(DEPTH);

   path_state_e       state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] pop_data_q, pop_data_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              pop_valid_q, pop_valid_d;
   logic              out_valid_q, out_valid_d;
   logic              replay_done_q, replay_done_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [AW-1:0]     mem_raddr;
   logic [DATA_W-1:0] mem_rdata;
   logic              is_full, is_empty;

   assign is_full  = (count_q == CNT_W'(DEPTH));
   assign is_empty = (count_q == '0);

   path_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (mem_waddr),
      .wr_data (push_data),
      .rd_addr (mem_raddr),
      .rd_data (mem_rdata)
   );

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      pop_data_d    = pop_data_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      overflow_d    = overflow_q;
      underflow_d   = underflow_q;
      pop_valid_d   = 1'b0;
      replay_done_d = 1'b0;
      mem_we        = 1'b0;
      mem_waddr     = count_q[AW-1:0];
      mem_raddr     = AW'(count_q - CNT_W'(1));

      if (clear) begin
         state_d     = SEARCH;
         count_d     = '0;
         rd_ptr_d    = '0;
         pop_data_d  = '0;
         out_data_d  = '0;
         out_valid_d = 1'b0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         case (state_q)
            SEARCH: begin
               if (replay_start) begin
                  if (!is_empty) begin
                     state_d     = REPLAY;
                     rd_ptr_d    = '0;
                     mem_raddr   = '0;
                     out_data_d  = mem_rdata;
                     out_valid_d = 1'b1;
                  end else begin
                     state_d       = FINISHED;
                     replay_done_d = 1'b1;
                  end
               end else if (push && pop && !is_empty) begin
                  // Replace top: old word leaves on pop_data, new word takes its slot
                  pop_data_d  = mem_rdata;
                  pop_valid_d = 1'b1;
                  mem_we      = 1'b1;
                  mem_waddr   = AW'(count_q - CNT_W'(1));
               end else if (push) begin
                  if (is_full) begin
                     overflow_d = 1'b1;
                  end else begin
                     mem_we  = 1'b1;
                     count_d = count_q + CNT_W'(1);
                  end
               end else if (pop) begin
                  if (is_empty) begin
                     underflow_d = 1'b1;
                  end else begin
                     pop_data_d  = mem_rdata;
                     pop_valid_d = 1'b1;
                     count_d     = count_q - CNT_W'(1);
                  end
               end
            end
            REPLAY: begin
               if (out_valid_q && out_ready) begin
                  if ((rd_ptr_q + CNT_W'(1)) < count_q) begin
                     rd_ptr_d   = rd_ptr_q + CNT_W'(1);
                     mem_raddr  = AW'(rd_ptr_q + CNT_W'(1));
                     out_data_d = mem_rdata;
                  end else begin
                     out_valid_d   = 1'b0;
                     state_d       = FINISHED;
                     replay_done_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= SEARCH;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         pop_data_q    <= '0;
         out_data_q    <= '0;
         pop_valid_q   <= 1'b0;
         out_valid_q   <= 1'b0;
         replay_done_q <= 1'b0;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         pop_data_q    <= pop_data_d;
         out_data_q    <= out_data_d;
         pop_valid_q   <= pop_valid_d;
         out_valid_q   <= out_valid_d;
         replay_done_q <= replay_done_d;
         overflow_q    <= overflow_d;
         underflow_q   <= underflow_d;
      end
   end

   assign pop_data    = pop_data_q;
   assign pop_valid   = pop_valid_q;
   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign replay_done = replay_done_q;
   assign mode        = state_q;
   assign count       = count_q;
   assign full        = is_full;
   assign empty       = is_empty;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

endmodule
`default_nettype wire
